if_id_reg: RTL and testbench

//   F->D pipeline register; sits directly downstream of the PC register and instruction memory.

---
 rtl/if_id_reg_if.sv | 47 ++++
 rtl/if_id_reg.sv | 119 +++++++++++
 tb/tb_if_id_reg.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/if_id_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg_if
// Brief    : F->D pipeline register bus: fetch-side inputs, hazard controls,
//            D-stage outputs. Perf counter signals exist with IF_ID_PERF_EN.
// Revision : 1.0  initial release
// ============================================================================
interface if_id_reg_if;
  logic        req;
  logic        stall;
  logic        flush;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_bd;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic [4:0]  d_exccode;
  logic        d_bd;
  logic        d_valid;
`ifdef IF_ID_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_bubble_cnt;

  modport master (
    output req, stall, flush, f_pc, f_instr, f_bd,
    input  d_pc, d_instr, d_exccode, d_bd, d_valid,
    input  perf_stall_cnt, perf_bubble_cnt
  );

  modport slave (
    input  req, stall, flush, f_pc, f_instr, f_bd,
    output d_pc, d_instr, d_exccode, d_bd, d_valid,
    output perf_stall_cnt, perf_bubble_cnt
  );
`else
  modport master (
    output req, stall, flush, f_pc, f_instr, f_bd,
    input  d_pc, d_instr, d_exccode, d_bd, d_valid
  );

  modport slave (
    input  req, stall, flush, f_pc, f_instr, f_bd,
    output d_pc, d_instr, d_exccode, d_bd, d_valid
  );
`endif
endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : F->D pipeline register with fetch AdEL detection, stall, flush
//            and exception redirect. Optional IF_ID_PERF_EN adds counters.
// Revision : 1.0  initial release
// ============================================================================
module if_id_reg #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] PC_HANDLER = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
  input  wire logic  clk,
  input  wire logic  reset,
  if_id_reg_if.slave bus
);

  localparam logic [4:0] c_EXC_NONE = 5'd0;
  localparam logic [4:0] c_EXC_ADEL = 5'd4;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [4:0]  r_exccode;
  logic        r_bd;
  logic        r_valid;

  logic        w_fetch_bad;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [4:0]  w_exccode_nxt;
  logic        w_bd_nxt;
  logic        w_valid_nxt;

  // Misaligned or outside the instruction memory window -> AdEL
  always_comb begin
    w_fetch_bad = (bus.f_pc[1:0] != 2'b00) || (bus.f_pc < IM_LO) || (bus.f_pc > IM_HI);
  end

  always_comb begin
    w_pc_nxt      = r_pc;
    w_instr_nxt   = r_instr;
    w_exccode_nxt = r_exccode;
    w_bd_nxt      = r_bd;
    w_valid_nxt   = r_valid;
    if (bus.req) begin
      w_pc_nxt      = PC_HANDLER;
      w_instr_nxt   = 32'h0;
      w_exccode_nxt = c_EXC_NONE;
      w_bd_nxt      = 1'b0;
      w_valid_nxt   = 1'b0;
    end else if (bus.stall) begin
      // hold: flush is dropped because F re-fetches the same instruction
      w_pc_nxt      = r_pc;
    end else if (bus.flush) begin
      w_pc_nxt      = bus.f_pc;
      w_instr_nxt   = 32'h0;
      w_exccode_nxt = c_EXC_NONE;
      w_bd_nxt      = 1'b0;
      w_valid_nxt   = 1'b0;
    end else begin
      w_pc_nxt      = bus.f_pc;
      w_instr_nxt   = w_fetch_bad ? 32'h0 : bus.f_instr;
      w_exccode_nxt = w_fetch_bad ? c_EXC_ADEL : c_EXC_NONE;
      w_bd_nxt      = bus.f_bd;
      w_valid_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= PC_RESET;
      r_instr   <= 32'h0;
      r_exccode <= c_EXC_NONE;
      r_bd      <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_exccode <= w_exccode_nxt;
      r_bd      <= w_bd_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  assign bus.d_pc      = r_pc;
  assign bus.d_instr   = r_instr;
  assign bus.d_exccode = r_exccode;
  assign bus.d_bd      = r_bd;
  assign bus.d_valid   = r_valid;

`ifdef IF_ID_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_bubble_cnt;
  logic        w_stall_evt;
  logic        w_bubble_evt;

  assign w_stall_evt  = bus.stall & ~bus.req;
  assign w_bubble_evt = bus.flush & ~bus.stall & ~bus.req;

  // Saturating counters; req does not clear them, only reset does
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall_cnt  <= 32'h0;
      r_perf_bubble_cnt <= 32'h0;
    end else begin
      if (w_stall_evt && (r_perf_stall_cnt != 32'hFFFF_FFFF))
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (w_bubble_evt && (r_perf_bubble_cnt != 32'hFFFF_FFFF))
        r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt  = r_perf_stall_cnt;
  assign bus.perf_bubble_cnt = r_perf_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_reg
// Brief    : Self-checking bench for if_id_reg: directed cases then random
//            traffic against a behavioural reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_id_reg;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  if_id_reg_if bus ();

  if_id_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state, updated from the behavioural rules each edge
  logic [31:0] m_pc, m_instr;
  logic [4:0]  m_exc;
  logic        m_bd, m_valid;
  longint      m_stall_cnt, m_bubble_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] pc);
    longint unsigned p;
    p = pc;
    return (p % 4 != 0) || (p < 64'h3000) || (p > 64'h6FFC);
  endfunction

  task automatic model_edge(input logic rs, input logic rq, input logic st, input logic fl,
                            input logic [31:0] pc, input logic [31:0] ins, input logic bd);
    if (rs) begin
      m_pc = 32'h3000; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
      m_stall_cnt = 0; m_bubble_cnt = 0;
    end else begin
      if (st && !rq && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if (fl && !st && !rq && m_bubble_cnt < 64'hFFFF_FFFF) m_bubble_cnt++;
      if (rq) begin
        m_pc = 32'h4180; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
      end else if (st) begin
        m_valid = m_valid;
      end else if (fl) begin
        m_pc = pc; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
      end else begin
        m_pc = pc; m_bd = bd; m_valid = 1;
        m_instr = is_bad(pc) ? 32'h0 : ins;
        m_exc   = is_bad(pc) ? 5'd4 : 5'd0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"},    bus.d_pc,            m_pc);
    check({tag, ".instr"}, bus.d_instr,         m_instr);
    check({tag, ".exc"},   32'(bus.d_exccode),  32'(m_exc));
    check({tag, ".bd"},    32'(bus.d_bd),       32'(m_bd));
    check({tag, ".valid"}, 32'(bus.d_valid),    32'(m_valid));
`ifdef IF_ID_PERF_EN
    check({tag, ".pstall"},  bus.perf_stall_cnt,  m_stall_cnt[31:0]);
    check({tag, ".pbubble"}, bus.perf_bubble_cnt, m_bubble_cnt[31:0]);
`endif
  endtask

  // Drive one cycle of inputs, take the edge, then compare 1 time unit later
  task automatic step(input string tag, input logic rs, input logic rq, input logic st,
                      input logic fl, input logic [31:0] pc, input logic [31:0] ins,
                      input logic bd);
    reset = rs; bus.req = rq; bus.stall = st; bus.flush = fl;
    bus.f_pc = pc; bus.f_instr = ins; bus.f_bd = bd;
    @(posedge clk);
    model_edge(rs, rq, st, fl, pc, ins, bd);
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic [31:0] pc, ins;
    int          r;
    n_checks = 0; n_errors = 0;
    m_stall_cnt = 0; m_bubble_cnt = 0;
    reset = 1'b1; bus.req = 0; bus.stall = 0; bus.flush = 0;
    bus.f_pc = 0; bus.f_instr = 0; bus.f_bd = 0;

    // Directed cases
    step("reset",    1, 0, 0, 0, 32'h0000_1234, 32'hDEAD_BEEF, 1);
    step("load",     0, 0, 0, 0, 32'h0000_3004, 32'h2408_0001, 1);
    step("misalign", 0, 0, 0, 0, 32'h0000_3002, 32'h1111_1111, 0);
    step("above_hi", 0, 0, 0, 0, 32'h0000_7000, 32'h2222_2222, 0);
    step("at_hi",    0, 0, 0, 0, 32'h0000_6FFC, 32'h3333_3333, 1);
    step("at_lo",    0, 0, 0, 0, 32'h0000_3000, 32'h4444_4444, 0);
    step("below_lo", 0, 0, 0, 0, 32'h0000_2FFC, 32'h5555_5555, 0);
    step("wrap",     0, 0, 0, 0, 32'hFFFF_FFFC, 32'h6666_6666, 0);
    step("load3008", 0, 0, 0, 0, 32'h0000_3008, 32'h7777_7777, 0);
    for (int i = 0; i < 3; i++)
      step("stall", 0, 0, 1, 0, 32'h0000_3100 + 32'(i * 4), 32'h8888_0000 + 32'(i), 1);
    step("stall_fl", 0, 0, 1, 1, 32'h0000_3200, 32'h9999_9999, 1);
    step("flush",    0, 0, 0, 1, 32'h0000_3300, 32'hAAAA_AAAA, 1);
    step("flush2",   0, 0, 0, 1, 32'h0000_3304, 32'hABAB_ABAB, 0);
    step("stall_rq", 0, 1, 1, 0, 32'h0000_3400, 32'hBBBB_BBBB, 1);
    step("post_rq",  0, 0, 1, 0, 32'h0000_3404, 32'hCCCC_CCCC, 1);
    step("reload",   0, 0, 0, 0, 32'h0000_3408, 32'hCDCD_CDCD, 1);
    step("rst_stl",  1, 0, 1, 0, 32'h0000_3500, 32'hDDDD_DDDD, 1);
    step("stl_aft",  0, 0, 1, 0, 32'h0000_3504, 32'hEEEE_EEEE, 1);

`ifdef IF_ID_PERF_EN
    // Saturation: jam the stall counter to all-ones, then keep stalling
    force dut.r_perf_stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_perf_stall_cnt;
    m_stall_cnt = 64'hFFFF_FFFF;
    step("sat1", 0, 0, 1, 0, 32'h0000_3600, 32'h0, 0);
    step("sat2", 0, 1, 1, 0, 32'h0000_3604, 32'h0, 0);
    step("sat3", 0, 0, 1, 0, 32'h0000_3608, 32'h0, 0);
    step("satrst", 1, 0, 0, 0, 32'h0000_360C, 32'h0, 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       pc = $urandom;
        1:       pc = 32'h0000_6FFC + 32'($urandom_range(0, 8));
        2:       pc = 32'h0000_2FF8 + 32'($urandom_range(0, 12));
        default: pc = 32'h0000_3000 + (32'($urandom_range(0, 32'h0FFF)) << 2);
      endcase
      ins = $urandom;
      step("rand",
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           pc, ins, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
